// File: rtl/serial_pkg.sv
// serial_pkg
// Shared constants and types for the serial receive synchronisation path.
//   BYTE_W        width of a framed byte
//   COM_BYTE      alignment/idle symbol, sent MSB first
//   ST_HUNT/ST_COUNT/ST_ACTIVE  state encodings used by rx_state_t
package serial_pkg;

   localparam int BYTE_W = 8;

   localparam logic [BYTE_W-1:0] COM_BYTE = 8'hBC;

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_COUNT  = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;

   typedef enum logic [1:0] {
      HUNT   = ST_HUNT,
      COUNT  = ST_COUNT,
      ACTIVE = ST_ACTIVE
   } rx_state_t;

endpackage

// File: rtl/serial_rx_sync_ctrl_com_detector.sv
// com_detector
// Serial-to-parallel shift register with a COM symbol comparator.
// Ports:
//   clk_32f  in   bit clock, one serial bit per rising edge
//   reset    in   synchronous, active-low
//   data_in  in   serial bit, MSB of each byte first
//   sr       out  last eight received bits, newest in bit 0
//   is_com   out  1 when sr currently holds the COM symbol
module com_detector
   import serial_pkg::*;
#(
   parameter logic [BYTE_W-1:0] COM_SYMBOL = COM_BYTE
) (
   input  logic              clk_32f,
   input  logic              reset,
   input  logic              data_in,
   output logic [BYTE_W-1:0] sr,
   output logic              is_com
);

   // Shift every cycle regardless of alignment; framing is decided upstream
   // by the phase counter, so this register never stalls.
   always_ff @(posedge clk_32f) begin
      if (!reset) begin
         sr <= '0;
      end else begin
         sr <= {sr[BYTE_W-2:0], data_in};
      end
   end

   // Bit-level match, valid at any bit offset; the FSM decides whether the
   // offset is the aligned one.
   assign is_com = (sr == COM_SYMBOL);

endmodule

// File: rtl/serial_rx_sync_ctrl.sv
// serial_rx_sync_ctrl
// Receive-side synchronisation controller: hunts for the COM symbol at any
// bit offset, confirms alignment with a run of COMs on byte boundaries, then
// frames every following byte onto a parallel output.
// Ports:
//   clk_32f    in   bit clock (only clock)
//   reset      in   synchronous, active-low
//   data_in    in   serial bit, MSB first
//   data_out   out  last framed byte, holds between strobes
//   byte_strb  out  one-cycle pulse when data_out updates (ACTIVE only)
//   valid_out  out  1 = data byte, 0 = COM/idle byte
//   active     out  1 while locked
module serial_rx_sync_ctrl
   import serial_pkg::*;
#(
   parameter logic [BYTE_W-1:0] COM_SYMBOL = COM_BYTE,
   parameter int unsigned       N_COM_LOCK = 4
) (
   input  logic              clk_32f,
   input  logic              reset,
   input  logic              data_in,
   output logic [BYTE_W-1:0] data_out,
   output logic              byte_strb,
   output logic              valid_out,
   output logic              active
);

   localparam logic [3:0] LOCK_CNT = 4'(N_COM_LOCK);

   logic [BYTE_W-1:0] sr;
   logic              is_com;
   rx_state_t         state;
   logic [2:0]        ph;
   logic [3:0]        com_cnt;
   logic              boundary;

   com_detector #(
      .COM_SYMBOL (COM_SYMBOL)
   ) u_com_detector (
      .clk_32f (clk_32f),
      .reset   (reset),
      .data_in (data_in),
      .sr      (sr),
      .is_com  (is_com)
   );

   assign boundary = (ph == 3'd0);

   // Single FSM: the phase counter free-runs and is re-anchored on the first
   // COM seen while hunting, so that ph wraps to zero exactly when the next
   // aligned byte has fully shifted in. All outputs are registered here.
   always_ff @(posedge clk_32f) begin
      if (!reset) begin
         state     <= HUNT;
         ph        <= 3'd0;
         com_cnt   <= 4'd0;
         data_out  <= '0;
         valid_out <= 1'b0;
         byte_strb <= 1'b0;
         active    <= 1'b0;
      end else begin
         ph        <= ph + 3'd1;
         byte_strb <= 1'b0;
         case (state)
            HUNT: begin
               // ph <= 1 makes ph reach 0 eight cycles after this match.
               if (is_com) begin
                  ph      <= 3'd1;
                  com_cnt <= 4'd1;
                  state   <= COUNT;
               end
            end
            COUNT: begin
               if (boundary) begin
                  if (is_com) begin
                     com_cnt <= com_cnt + 4'd1;
                     if (com_cnt + 4'd1 == LOCK_CNT) begin
                        state  <= ACTIVE;
                        active <= 1'b1;
                     end
                  end else begin
                     // Misaligned or broken run; hunting resumes next cycle.
                     com_cnt <= 4'd0;
                     state   <= HUNT;
                  end
               end
            end
            ACTIVE: begin
               if (boundary) begin
                  data_out  <= sr;
                  valid_out <= !is_com;
                  byte_strb <= 1'b1;
               end
            end
            default: begin
               state <= HUNT;
            end
         endcase
      end
   end

endmodule
